// File: rtl/dmac_ch_arb.sv
// ============================================================================
// dmac_ch_arb : PSX DMAC channel arbiter / sequencer for the shared engine
// Rev 1.0
// ============================================================================
`default_nettype none

module dmac_ch_arb (
    input  logic        CLK,
    input  logic        RST_ASYNC,
    input  logic        RST_SYNC,
    input  logic        EN,
    input  logic [31:0] CFG_DMAC_PCR_IN,
    input  logic [6:0]  CFG_DMAC_CHCR_TR_IN,
    input  logic [6:0]  CFG_DMAC_CHCR_CO_IN,
    input  logic [6:0]  DEV_REQ_IN,
    output logic        ENG_START_OUT,
    output logic [2:0]  ENG_CH_OUT,
    input  logic        ENG_DONE_IN,
    output logic [6:0]  CFG_DMAC_CHCR_TR_CLR_OUT,
    output logic [6:0]  CH_DONE_OUT,
    output logic        BUSY_OUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ch;
    logic [6:0] w_elig;
    logic       w_any;
    logic [2:0] w_win;
    logic [2:0] w_best_prio;
    logic       w_clear;
    logic [6:0] w_ch_onehot;

    genvar gi;
    for (gi = 0; gi < 7; gi++) begin : g_elig
        assign w_elig[gi] = CFG_DMAC_CHCR_TR_IN[gi] & CFG_DMAC_PCR_IN[4*gi+3]
                          & (CFG_DMAC_CHCR_CO_IN[gi] | DEV_REQ_IN[gi]);
    end

    // Ascending scan with <= lets the higher channel win a priority tie.
    always_comb begin
        w_any       = 1'b0;
        w_win       = 3'd0;
        w_best_prio = 3'd7;
        for (int n = 0; n < 7; n++) begin
            if (w_elig[n] && (CFG_DMAC_PCR_IN[4*n +: 3] <= w_best_prio)) begin
                w_any       = 1'b1;
                w_win       = 3'(n);
                w_best_prio = CFG_DMAC_PCR_IN[4*n +: 3];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (ENG_DONE_IN) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_state <= S_IDLE;
            r_ch    <= 3'd0;
        end else if (RST_SYNC) begin
            r_state <= S_IDLE;
            r_ch    <= 3'd0;
        end else if (EN) begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any)
                r_ch <= w_win;
        end
    end

    // Strobes are qualified by the clock enable so a frozen state never repeats them.
    assign w_clear     = (r_state == S_CLEAR) && EN;
    assign w_ch_onehot = 7'b000_0001 << r_ch;

    assign ENG_START_OUT            = (r_state == S_START) && EN;
    assign ENG_CH_OUT               = r_ch;
    assign CFG_DMAC_CHCR_TR_CLR_OUT = w_clear ? w_ch_onehot : 7'd0;
    assign CH_DONE_OUT              = w_clear ? w_ch_onehot : 7'd0;
    assign BUSY_OUT                 = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmac_ch_arb.sv
// ============================================================================
// tb_dmac_ch_arb : directed self-checking bench for dmac_ch_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmac_ch_arb;

    logic        clk;
    logic        rst_async;
    logic        rst_sync;
    logic        en;
    logic [31:0] pcr;
    logic [6:0]  tr;
    logic [6:0]  co;
    logic [6:0]  dreq;
    logic        done;
    logic        start;
    logic [2:0]  ch;
    logic [6:0]  clr;
    logic [6:0]  chdone;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    dmac_ch_arb dut (
        .CLK                      (clk),
        .RST_ASYNC                (rst_async),
        .RST_SYNC                 (rst_sync),
        .EN                       (en),
        .CFG_DMAC_PCR_IN          (pcr),
        .CFG_DMAC_CHCR_TR_IN      (tr),
        .CFG_DMAC_CHCR_CO_IN      (co),
        .DEV_REQ_IN               (dreq),
        .ENG_START_OUT            (start),
        .ENG_CH_OUT               (ch),
        .ENG_DONE_IN              (done),
        .CFG_DMAC_CHCR_TR_CLR_OUT (clr),
        .CH_DONE_OUT              (chdone),
        .BUSY_OUT                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From START: WAIT, done pulse, CLEAR, back to IDLE.
    task automatic finish_xfer();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tr   = 7'd0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b exp 0", start); end
        n_tests++; if (ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch got %0d exp 0", ch); end
        n_tests++; if (clr !== 7'd0 || chdone !== 7'd0) begin n_fail++; $display("FAIL rst_strobes clr %b done %b exp 0", clr, chdone); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        tick();
        rst_async = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_after got %b exp 0", busy); end
    endtask

    task automatic test_single();
        pcr = 32'h0800_0000; tr = 7'b100_0000; co = 7'b100_0000;
        tick();
        n_tests++; if (start !== 1'b1 || ch !== 3'd6) begin n_fail++; $display("FAIL single_start start %b ch %0d exp 1/6", start, ch); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
        tick();
        n_tests++; if (start !== 1'b0 || clr !== 7'd0) begin n_fail++; $display("FAIL single_wait start %b clr %b exp 0/0", start, clr); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++; if (clr !== 7'b100_0000) begin n_fail++; $display("FAIL single_trclr got %b exp 1000000", clr); end
        n_tests++; if (chdone !== 7'b100_0000) begin n_fail++; $display("FAIL single_chdone got %b exp 1000000", chdone); end
        tr = 7'd0;
        tick();
        n_tests++; if (busy !== 1'b0 || clr !== 7'd0) begin n_fail++; $display("FAIL single_idle busy %b clr %b exp 0/0", busy, clr); end
        n_tests++; if (ch !== 3'd6) begin n_fail++; $display("FAIL single_ch_hold got %0d exp 6", ch); end
    endtask

    task automatic test_priority();
        int order[3] = '{1, 0, 2};
        pcr = 32'h0000_0B9A; tr = 7'b000_0111; co = 7'b111_1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (start !== 1'b1 || ch !== 3'(order[k])) begin n_fail++; $display("FAIL prio_grant%0d start %b ch %0d exp 1/%0d", k, start, ch, order[k]); end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            n_tests++; if (clr !== (7'b1 << order[k])) begin n_fail++; $display("FAIL prio_clr%0d got %b exp ch %0d", k, clr, order[k]); end
            tr[order[k]] = 1'b0;
            tick();
        end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_drain busy %b exp 0", busy); end
    endtask

    task automatic test_tie();
        pcr = 32'h00C0_C000; co = 7'd0; tr = 7'b010_1000; dreq = 7'b000_1000;
        tick();
        n_tests++; if (start !== 1'b1 || ch !== 3'd3) begin n_fail++; $display("FAIL tie_devreq start %b ch %0d exp 1/3", start, ch); end
        finish_xfer();
        tr = 7'b010_1000; dreq = 7'b010_1000;
        tick();
        n_tests++; if (start !== 1'b1 || ch !== 3'd5) begin n_fail++; $display("FAIL tie_high start %b ch %0d exp 1/5", start, ch); end
        finish_xfer();
        dreq = 7'd0;
    endtask

    task automatic test_robust();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++; if (busy !== 1'b0 || clr !== 7'd0) begin n_fail++; $display("FAIL done_in_idle busy %b clr %b exp 0/0", busy, clr); end
        pcr = 32'h0800_0000; tr = 7'b100_0000; co = 7'b100_0000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b1 || clr !== 7'd0) begin n_fail++; $display("FAIL done_in_start busy %b clr %b exp 1/0", busy, clr); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++; if (clr !== 7'b100_0000) begin n_fail++; $display("FAIL done_late_clr got %b exp 1000000", clr); end
        tr = 7'd0;
        tick();

        // EN dropped right after entering START
        tr = 7'b100_0000;
        tick();
        en = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL en_low%0d start %b busy %b exp 0/1", k, start, busy); end
            tick();
        end
        en = 1'b1;
        #1;
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL en_resume start %b exp 1", start); end
        tick();
        n_tests++; if (start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL en_once start %b busy %b exp 0/1", start, busy); end
        done = 1'b1;
        tick();
        done = 1'b0;
        tr = 7'd0;
        tick();

        // higher-priority channel appears during WAIT
        pcr = 32'h000D_0008; tr = 7'b001_0000; co = 7'b111_1111;
        tick();
        n_tests++; if (ch !== 3'd4 || start !== 1'b1) begin n_fail++; $display("FAIL preempt_first ch %0d start %b exp 4/1", ch, start); end
        tick();
        tr = 7'b001_0001;
        tick(); tick();
        n_tests++; if (ch !== 3'd4 || busy !== 1'b1 || clr !== 7'd0) begin n_fail++; $display("FAIL preempt_hold ch %0d busy %b clr %b exp 4/1/0", ch, busy, clr); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++; if (clr !== 7'b001_0000) begin n_fail++; $display("FAIL preempt_clr got %b exp 0010000", clr); end
        tr = 7'b000_0001;
        tick(); tick();
        n_tests++; if (ch !== 3'd0 || start !== 1'b1) begin n_fail++; $display("FAIL preempt_next ch %0d start %b exp 0/1", ch, start); end
        finish_xfer();
    endtask

    task automatic test_reset_mid_wait();
        pcr = 32'h0000_0900; tr = 7'b000_0100; co = 7'b000_0100;
        tick();
        tick();
        n_tests++; if (busy !== 1'b1 || ch !== 3'd2) begin n_fail++; $display("FAIL rstw_pre busy %b ch %0d exp 1/2", busy, ch); end
        rst_async = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || ch !== 3'd0 || start !== 1'b0 || clr !== 7'd0 || chdone !== 7'd0) begin n_fail++; $display("FAIL rstw_async busy %b ch %0d start %b clr %b done %b exp all 0", busy, ch, start, clr, chdone); end
        tick();
        tr = 7'd0;
        rst_async = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0 || clr !== 7'd0) begin n_fail++; $display("FAIL rstw_after busy %b clr %b exp 0/0", busy, clr); end

        tr = 7'b000_0100;
        tick();
        tick();
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        tr = 7'd0;
        n_tests++; if (busy !== 1'b0 || ch !== 3'd0 || clr !== 7'd0) begin n_fail++; $display("FAIL rstw_sync busy %b ch %0d clr %b exp 0/0/0", busy, ch, clr); end
        tick();
        n_tests++; if (busy !== 1'b0 || clr !== 7'd0) begin n_fail++; $display("FAIL rstw_sync_after busy %b clr %b exp 0/0", busy, clr); end
    endtask

    initial begin
        rst_async = 1'b1; rst_sync = 1'b0; en = 1'b1;
        pcr = 32'd0; tr = 7'd0; co = 7'd0; dreq = 7'd0; done = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_tie();
        test_robust();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
